index_counter_2d: RTL and testbench
===================================

INDEX_COUNTER_2D -- requirements
Module: index_counter_2d

Interface
REQ-001 SHALL have parameter ROWS, default 5, number of row positions (>=2).
REQ-002 SHALL have parameter COLS, default 5, number of column positions (>=2).
REQ-003 SHALL have parameter ROUNDS, default 24, number of full passes per job (>=2).
REQ-004 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port init0  input  1  synchronous clear to start position.
REQ-007 SHALL have port enc  input  1  advance-one-step enable.
REQ-008 SHALL have port dir  input  1  0 = count up, 1 = count down.
REQ-009 SHALL have port hold_last  input  1  1 = stop at terminal; 0 = wrap.
REQ-010 SHALL have port cnt  output  clog2(ROWS*COLS)  linear index row*COLS+col.
REQ-011 SHALL have port row  output  clog2(ROWS)  current row index.
REQ-012 SHALL have port col  output  clog2(COLS)  current column index.
REQ-013 SHALL have port rnd  output  clog2(ROUNDS)  current pass number.
REQ-014 SHALL have port co  output  1  terminal-position flag, combinational.
REQ-015 SHALL have port done  output  1  last-pass terminal flag, combinational.

Function
REQ-016 Start position SHALL be (0,0) when dir=0 and (ROWS-1,COLS-1) when dir=1; terminal position is the opposite corner.
REQ-017 co SHALL be 1 exactly when (row,col) equals the terminal position for the current dir.
REQ-018 With enc=1 and co=0, col SHALL step by one (+1 up, -1 down); on column wrap (COLS-1->0 up, 0->COLS-1 down), row SHALL step one the same way in the same edge.
REQ-019 With enc=1, co=1 and hold_last=0, the next edge SHALL load the start position (wrap event); with hold_last=1, position SHALL hold.
REQ-020 With enc=0, row, col and rnd SHALL hold.
REQ-021 cnt SHALL be a registered copy equal to row*COLS+col every cycle; no multiplier on the output path.
REQ-022 init0 SHALL take priority over enc: the next edge loads the start position for current dir and clears rnd.
REQ-023 A dir change SHALL not move the position; the next enc steps from the current position in the new direction, and co re-evaluates immediately.
REQ-024 rnd SHALL increment on every wrap event, and on a wrap event with rnd=ROUNDS-1 SHALL return to 0.
REQ-025 done SHALL equal co AND (rnd==ROUNDS-1).

Reset
REQ-026 rst=1 SHALL asynchronously force row=0, col=0, cnt=0, rnd=0, independent of dir and clk.
REQ-027 Consequently co=0 and done=0 during reset for dir=0, and co=0 for dir=1 (start corner is not (0,0) going down; first edge after reset continues from (0,0)).
REQ-028 Reset asserted mid-pass SHALL discard position and round with no residual state.

Configuration
REQ-029 Macro INDEX_COUNTER_ROUND_EN SHALL control the round counter.
REQ-030 With it defined, rnd and done SHALL behave per REQ-024/025.
REQ-031 Without it, rnd SHALL be constant 0, done SHALL equal co, and no round register is built; ports remain present.

Structure
REQ-032 A shared package SHALL hold the clog2 width function, the default ROWS/COLS/ROUNDS constants and the dir encoding constants (DIR_UP=0, DIR_DN=1).
REQ-033 A sub-module axis_counter (modulus N, enable, direction, load-start, carry-out) SHALL implement one axis; it is instantiated twice, col carry-out driving row enable.

Verification
REQ-034 Reset, dir=0, enc=1 for 24 cycles -> cnt 0..24, co=1 only at (4,4)/cnt=24; next edge cnt=0, rnd=1.
REQ-035 dir=1, init0 pulse then enc=1 -> cnt 24,23,...,0; at cnt=0 co=1; hold_last=1 keeps cnt=0 for 5 further enc cycles.
REQ-036 enc=1 for 25*24 cycles, dir=0 -> done=1 exactly once at rnd=23,cnt=24; following edge rnd=0, cnt=0.
REQ-037 At cnt=12 assert init0 and enc together -> next cnt=0, rnd=0; flip dir at cnt=7 -> next enc gives cnt=6, co unchanged 0.
REQ-038 Assert rst between clock edges at cnt=17, rnd=3 -> outputs 0 immediately, before the next edge.
REQ-039 Repeat REQ-034 with ROWS=3, COLS=7, and with INDEX_COUNTER_ROUND_EN undefined -> rnd stays 0, done mirrors co.

Source files
------------

// File: rtl/index_counter_2d_pkg.sv
// Shared constants and helpers for the 2-D index counter.
// Holds the width function, default geometry and direction encoding.
package index_counter_2d_pkg;

  localparam int DEF_ROWS   = 5;
  localparam int DEF_COLS   = 5;
  localparam int DEF_ROUNDS = 24;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Bits needed to hold the values 0..n-1; callers guarantee n >= 2.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/index_counter_2d_axis.sv
// One axis of the 2-D index counter: modulo-N up/down counter.
// The carry-out flags the terminal value for the current direction.
module axis_counter
  import index_counter_2d_pkg::*;
#(
  parameter int N = DEF_COLS,
  parameter int W = clog2_f(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  output logic [W-1:0] val,
  output logic         co
);

  localparam logic [W-1:0] MAX_V  = W'(N - 1);
  localparam logic [W-1:0] ZERO_V = W'(0);
  localparam logic [W-1:0] ONE_V  = W'(1);

  logic [W-1:0] val_d;
  logic [W-1:0] val_q;
  logic [W-1:0] start_s;
  logic [W-1:0] term_s;

  // Start and terminal values swap with direction.
  always_comb begin
    start_s = ZERO_V;
    term_s  = MAX_V;
    if (dir == DIR_DN) begin
      start_s = MAX_V;
      term_s  = ZERO_V;
    end else begin
      start_s = ZERO_V;
      term_s  = MAX_V;
    end
  end

  assign co = (val_q == term_s);

  // Next value: load wins, then a step that wraps at the terminal.
  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = start_s;
    end else if (en) begin
      if (co) begin
        val_d = start_s;
      end else if (dir == DIR_UP) begin
        val_d = val_q + ONE_V;
      end else begin
        val_d = val_q - ONE_V;
      end
    end else begin
      val_d = val_q;
    end
  end

  // Axis state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= ZERO_V;
    end else begin
      val_q <= val_d;
    end
  end

  assign val = val_q;

endmodule

// File: rtl/index_counter_2d.sv
// Row/column index counter with optional pass counter.
// Define INDEX_COUNTER_ROUND_EN to build the round register; otherwise rnd is tied to 0.
module index_counter_2d
  import index_counter_2d_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ROUNDS = DEF_ROUNDS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init0,
  input  logic                             enc,
  input  logic                             dir,
  input  logic                             hold_last,
  output logic [clog2_f(ROWS*COLS)-1:0]    cnt,
  output logic [clog2_f(ROWS)-1:0]         row,
  output logic [clog2_f(COLS)-1:0]         col,
  output logic [clog2_f(ROUNDS)-1:0]       rnd,
  output logic                             co,
  output logic                             done
);

  localparam int CW  = clog2_f(ROWS * COLS);
  localparam int RW  = clog2_f(ROWS);
  localparam int LW  = clog2_f(COLS);
  localparam int NW  = clog2_f(ROUNDS);
  localparam logic [CW-1:0] LAST_CNT = CW'(ROWS * COLS - 1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic          row_co_s;
  logic          col_co_s;
  logic          at_term_s;
  logic          step_s;
  logic          wrap_s;
  logic          load_s;
  logic          co_s;
  logic [RW-1:0] row_s;
  logic [LW-1:0] col_s;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  assign at_term_s = row_co_s & col_co_s;
  assign step_s    = enc & ~at_term_s & ~init0;
  assign wrap_s    = enc & at_term_s & ~hold_last & ~init0;
  assign load_s    = init0 | wrap_s;

  axis_counter #(.N(COLS), .W(LW)) u_col (
    .clk  (clk),
    .rst  (rst),
    .en   (step_s),
    .dir  (dir),
    .load (load_s),
    .val  (col_s),
    .co   (col_co_s)
  );

  axis_counter #(.N(ROWS), .W(RW)) u_row (
    .clk  (clk),
    .rst  (rst),
    .en   (step_s & col_co_s),
    .dir  (dir),
    .load (load_s),
    .val  (row_s),
    .co   (row_co_s)
  );

  // Linear index tracks the axes by +/-1 so no multiplier is needed.
  always_comb begin
    cnt_d = cnt_q;
    if (load_s) begin
      cnt_d = (dir == DIR_DN) ? LAST_CNT : ZERO_CNT;
    end else if (step_s) begin
      cnt_d = (dir == DIR_UP) ? (cnt_q + ONE_CNT) : (cnt_q - ONE_CNT);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Linear index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= ZERO_CNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reset parks at (0,0), which is the down-terminal; keep co quiet while held.
  assign co_s = at_term_s & ~rst;
  assign co   = co_s;
  assign cnt  = cnt_q;
  assign row  = row_s;
  assign col  = col_s;

`ifdef INDEX_COUNTER_ROUND_EN
  localparam logic [NW-1:0] LAST_RND = NW'(ROUNDS - 1);
  localparam logic [NW-1:0] ZERO_RND = NW'(0);
  localparam logic [NW-1:0] ONE_RND  = NW'(1);

  logic [NW-1:0] rnd_d;
  logic [NW-1:0] rnd_q;

  // Pass counter advances on each wrap and rolls over after the last pass.
  always_comb begin
    rnd_d = rnd_q;
    if (init0) begin
      rnd_d = ZERO_RND;
    end else if (wrap_s) begin
      rnd_d = (rnd_q == LAST_RND) ? ZERO_RND : (rnd_q + ONE_RND);
    end else begin
      rnd_d = rnd_q;
    end
  end

  // Pass counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_q <= ZERO_RND;
    end else begin
      rnd_q <= rnd_d;
    end
  end

  assign rnd  = rnd_q;
  assign done = co_s & (rnd_q == LAST_RND);
`else
  assign rnd  = NW'(0);
  assign done = co_s;
`endif

endmodule

// File: tb/tb_index_counter_2d.sv
// Randomized scoreboard bench for index_counter_2d: a 5x5x24 and a 3x7x3 instance
// share stimulus and are checked against a linear-index reference model.
module tb_index_counter_2d;
  import index_counter_2d_pkg::*;

`ifdef INDEX_COUNTER_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef struct {
    int cnt;
    int row;
    int col;
    int rnd;
    bit co;
    bit done;
  } exp_t;

  logic clk, rst, init0, enc, dir, hold_last;
  logic [clog2_f(25)-1:0] cnt0;
  logic [clog2_f(5)-1:0]  row0;
  logic [clog2_f(5)-1:0]  col0;
  logic [clog2_f(24)-1:0] rnd0;
  logic                   co0, done0;
  logic [clog2_f(21)-1:0] cnt1;
  logic [clog2_f(3)-1:0]  row1;
  logic [clog2_f(7)-1:0]  col1;
  logic [clog2_f(3)-1:0]  rnd1;
  logic                   co1, done1;

  int   n_total = 0;
  int   n_pass  = 0;
  int   rows_m [2] = '{5, 3};
  int   cols_m [2] = '{5, 7};
  int   rnds_m [2] = '{24, 3};
  int   idx_m  [2] = '{0, 0};
  int   pass_m [2] = '{0, 0};
  exp_t q0[$];
  exp_t q1[$];

  index_counter_2d #(.ROWS(5), .COLS(5), .ROUNDS(24)) dut0 (
    .clk(clk), .rst(rst), .init0(init0), .enc(enc), .dir(dir), .hold_last(hold_last),
    .cnt(cnt0), .row(row0), .col(col0), .rnd(rnd0), .co(co0), .done(done0)
  );

  index_counter_2d #(.ROWS(3), .COLS(7), .ROUNDS(3)) dut1 (
    .clk(clk), .rst(rst), .init0(init0), .enc(enc), .dir(dir), .hold_last(hold_last),
    .cnt(cnt1), .row(row1), .col(col1), .rnd(rnd1), .co(co1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input int act, input int req);
    n_total++;
    if (act != req) begin
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end else begin
      n_pass++;
    end
  endfunction

  // Reference: one linear position walked corner to corner, rounds counted on wraps.
  task automatic model_push(input int k, input bit r, input bit i0, input bit e,
                            input bit d, input bit h);
    int   total;
    int   term;
    int   start;
    exp_t x;
    total = rows_m[k] * cols_m[k];
    term  = d ? 0 : total - 1;
    start = d ? total - 1 : 0;
    if (r) begin
      idx_m[k]  = 0;
      pass_m[k] = 0;
    end else if (i0) begin
      idx_m[k]  = start;
      pass_m[k] = 0;
    end else if (e) begin
      if (idx_m[k] == term) begin
        if (!h) begin
          idx_m[k]  = start;
          pass_m[k] = (pass_m[k] + 1) % rnds_m[k];
        end
      end else begin
        idx_m[k] = idx_m[k] + (d ? -1 : 1);
      end
    end
    if (!ROUND_EN) pass_m[k] = 0;
    x.cnt  = idx_m[k];
    x.row  = idx_m[k] / cols_m[k];
    x.col  = idx_m[k] % cols_m[k];
    x.rnd  = pass_m[k];
    x.co   = !r && (idx_m[k] == term);
    x.done = x.co && (!ROUND_EN || pass_m[k] == rnds_m[k] - 1);
    if (k == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic step(input bit r, input bit i0, input bit e, input bit d, input bit h);
    @(negedge clk);
    rst = r; init0 = i0; enc = e; dir = d; hold_last = h;
    model_push(0, r, i0, e, d, h);
    model_push(1, r, i0, e, d, h);
  endtask

  // Reset raised between edges must clear outputs before any clock edge.
  task automatic async_reset();
    @(negedge clk);
    init0 = 1'b0; enc = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt0", int'(cnt0), 0);
    chk("arst_row0", int'(row0), 0);
    chk("arst_col0", int'(col0), 0);
    chk("arst_rnd0", int'(rnd0), 0);
    chk("arst_co0", int'(co0), 0);
    chk("arst_done0", int'(done0), 0);
    chk("arst_cnt1", int'(cnt1), 0);
    chk("arst_rnd1", int'(rnd1), 0);
    model_push(0, 1'b1, 1'b0, 1'b0, dir, hold_last);
    model_push(1, 1'b1, 1'b0, 1'b0, dir, hold_last);
  endtask

  task automatic cmp(input string p, input exp_t e, input int c, input int r,
                     input int l, input int n, input int o, input int dn);
    chk({p, "_cnt"}, c, e.cnt);
    chk({p, "_row"}, r, e.row);
    chk({p, "_col"}, l, e.col);
    chk({p, "_rnd"}, n, e.rnd);
    chk({p, "_co"}, o, int'(e.co));
    chk({p, "_done"}, dn, int'(e.done));
  endtask

  // Monitor: one expected entry per instance per clock, checked after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) begin
        e = q0.pop_front();
        cmp("d0", e, int'(cnt0), int'(row0), int'(col0), int'(rnd0), int'(co0), int'(done0));
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        cmp("d1", e, int'(cnt1), int'(row1), int'(col1), int'(rnd1), int'(co1), int'(done1));
      end
    end
  end

  initial begin
    bit d_r;
    rst = 1'b1; init0 = 1'b0; enc = 1'b0; dir = 1'b0; hold_last = 1'b0;
    // Reset held with both directions, then an up sweep through one wrap.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (26) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Down sweep from the top corner, then hold at the terminal.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (24) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    // Full job of 24 passes, then into pass 3 at index 17 and reset mid-cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (600) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (92) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    async_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // init0 together with enc, then a direction flip mid-pass.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    // Random traffic.
    d_r = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) d_r = ~d_r;
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), d_r, ($urandom_range(0, 3) == 0));
    end
    step(1'b0, 1'b0, 1'b0, d_r, 1'b0);
    @(posedge clk);
    #2;
    chk("queue_drain", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
